// File: rtl/toeplitz_hash_if.sv
// ----------------------------------------------------------------------------
// toeplitz_hash_if
// Purpose : Handshake bundle for toeplitz_hash. It carries a word stream in
//           and a hash stream out.
// Signals : in_valid/in_ready/in_data   word input channel (BS bits)
//           out_valid/out_ready/out_data hash output channel (L bits)
//           busy                        block partially accepted
// Modports: master = producer/consumer side, slave = hash engine side
// ----------------------------------------------------------------------------
interface toeplitz_hash_if #(
   parameter int unsigned BS = 64,
   parameter int unsigned L  = 128
) ();
   logic          in_valid;
   logic          in_ready;
   logic [BS-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [L-1:0]  out_data;
   logic          busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/toeplitz_hash.sv
// ----------------------------------------------------------------------------
// toeplitz_hash
// Purpose : Computes y = T * x over GF(2). T is the L x N Toeplitz matrix built
//           from row0/col0. x arrives as W = N/BS words. The hash is presented
//           one cycle after the last word and held until it is accepted.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous active-low reset
//           row0   - Toeplitz first row (N bits)
//           col0   - Toeplitz first column (L bits, bit 0 unused)
//           bus    - toeplitz_hash_if.slave (word in / hash out / busy)
// ----------------------------------------------------------------------------
module toeplitz_hash #(
   parameter int unsigned BS = 64,
   parameter int unsigned N  = 256,
   parameter int unsigned L  = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     row0,
   input  logic [L-1:0]     col0,
   toeplitz_hash_if.slave   bus
);

   localparam int unsigned W  = N / BS;
   localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(W - 1);

   typedef enum logic {ST_ACCUM, ST_DONE} state_t;

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [L-1:0]    r_acc;
   logic [L-1:0]    r_out_data;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            r_busy;

   state_t          w_state_nx;
   logic [KW-1:0]   w_k_nx;
   logic [L-1:0]    w_acc_nx;
   logic [L-1:0]    w_out_data_nx;
   logic            w_in_ready_nx;
   logic            w_out_valid_nx;
   logic            w_busy_nx;
   logic            w_xfer;
   logic [L-1:0]    w_contrib;
   int unsigned     w_base;

   // r_in_ready is only ever high in ACCUM, so it doubles as the state qualifier
   assign w_xfer = bus.in_valid && r_in_ready;
   assign w_base = int'(r_k) * BS;

   // Contribution of the current word: columns w_base .. w_base+BS-1 of T
   always_comb begin
      w_contrib = '0;
      for (int unsigned i = 0; i < L; i++) begin
         for (int unsigned b = 0; b < BS; b++) begin
            int unsigned j;
            logic        t_bit;
            j = w_base + b;
            if (j >= i) t_bit = row0[RW'(j - i)];
            else        t_bit = col0[CW'(i - j)];
            w_contrib[i] = w_contrib[i] ^ (t_bit & bus.in_data[b]);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nx    = r_state;
      w_k_nx        = r_k;
      w_acc_nx      = r_acc;
      w_out_data_nx = r_out_data;
      case (r_state)
         ST_ACCUM: begin
            if (w_xfer) begin
               if (r_k == K_LAST) begin
                  w_out_data_nx = r_acc ^ w_contrib;
                  w_acc_nx      = '0;
                  w_k_nx        = '0;
                  w_state_nx    = ST_DONE;
               end else begin
                  w_acc_nx = r_acc ^ w_contrib;
                  w_k_nx   = r_k + KW'(1);
               end
            end
         end
         ST_DONE: begin
            if (bus.out_ready) w_state_nx = ST_ACCUM;
         end
         default: w_state_nx = ST_ACCUM;
      endcase
      w_in_ready_nx  = (w_state_nx == ST_ACCUM);
      w_out_valid_nx = (w_state_nx == ST_DONE);
      w_busy_nx      = (w_k_nx != '0);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_ACCUM;
         r_k         <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_k         <= w_k_nx;
         r_acc       <= w_acc_nx;
         r_out_data  <= w_out_data_nx;
         r_in_ready  <= w_in_ready_nx;
         r_out_valid <= w_out_valid_nx;
         r_busy      <= w_busy_nx;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.busy      = r_busy;

endmodule
